setpoint_sequencer: RTL and testbench

SETPOINT_SEQUENCER -- requirements
Module: setpoint_sequencer

---
 rtl/control_pkg.sv | 11 +
 rtl/dwell_timer.sv | 30 +++
 rtl/setpoint_sequencer.sv | 132 +++++++++++++
 tb/tb_setpoint_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared state encoding for the setpoint sequencer
package control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEEK  = 2'd1,
    ST_DWELL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - loadable dwell down-counter with zero flag
// Load wins over counting; the counter parks at zero instead of wrapping.
module dwell_timer #(
  parameter int width = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [width-1:0] i_load_value,
  input  logic             i_count_en,
  output logic             o_zero
);

  localparam logic [width-1:0] one = width'(1);

  logic [width-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_count_en && (r_count != '0)) begin
      r_count <= r_count - one;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/setpoint_sequencer.sv
// rtl/setpoint_sequencer.sv - steps a follower through stored setpoints with dwell
// Build option SETPOINT_SEQUENCER_LOOP_EN: wrap from the last slot back to slot 0 instead of finishing.
module setpoint_sequencer
  import control_pkg::*;
#(
  parameter int                   bitwidth       = 8,
  parameter int                   depth          = 4,
  parameter int                   dwell_bitwidth = 16,
  parameter logic [bitwidth-1:0]  initial_value  = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      write_enable,
  input  logic [$clog2(depth)-1:0]  write_address,
  input  logic [bitwidth-1:0]       write_data,
  input  logic [dwell_bitwidth-1:0] dwell_cycles,
  input  logic                      start,
  input  logic                      abort,
  input  logic [bitwidth-1:0]       actual_value,
  output logic [bitwidth-1:0]       target_value,
  output logic [$clog2(depth)-1:0]  index,
  output logic                      busy,
  output logic                      done
);

  localparam int aw = $clog2(depth);
  localparam logic [aw-1:0] last_index = aw'(depth - 1);
  localparam logic [aw-1:0] one_index  = aw'(1);

  logic [bitwidth-1:0] r_slots [depth];

  state_t              r_state;
  state_t              w_next_state;
  logic [bitwidth-1:0] r_target;
  logic [bitwidth-1:0] w_next_target;
  logic [aw-1:0]       r_index;
  logic [aw-1:0]       w_next_index;
  logic [aw-1:0]       w_index_inc;
  logic                r_busy;
  logic                r_done;
  logic                w_timer_load;
  logic                w_timer_zero;

  // Slots are deliberately outside reset so a reset keeps the programmed profile.
  always_ff @(posedge clock) begin
    if (!reset && write_enable) begin
      r_slots[write_address] <= write_data;
    end
  end

  dwell_timer #(
    .width (dwell_bitwidth)
  ) u_dwell_timer (
    .clock        (clock),
    .reset        (reset),
    .i_load       (w_timer_load),
    .i_load_value (dwell_cycles),
    .i_count_en   (r_state == ST_DWELL),
    .o_zero       (w_timer_zero)
  );

  assign w_index_inc = r_index + one_index;

  always_comb begin
    w_next_state  = r_state;
    w_next_target = r_target;
    w_next_index  = r_index;
    w_timer_load  = 1'b0;
    if (abort) begin
      w_next_state  = ST_IDLE;
      w_next_target = actual_value;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_next_state  = ST_SEEK;
            w_next_index  = '0;
            w_next_target = r_slots[0];
          end
        end
        ST_SEEK: begin
          if (actual_value == r_target) begin
            w_timer_load = 1'b1;
            w_next_state = ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (w_timer_zero) begin
            if (r_index != last_index) begin
              w_next_state  = ST_SEEK;
              w_next_index  = w_index_inc;
              w_next_target = r_slots[w_index_inc];
            end else begin
`ifdef SETPOINT_SEQUENCER_LOOP_EN
              w_next_state  = ST_SEEK;
              w_next_index  = '0;
              w_next_target = r_slots[0];
`else
              w_next_state  = ST_DONE;
`endif
            end
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_target <= initial_value;
      r_index  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_target <= w_next_target;
      r_index  <= w_next_index;
      r_busy   <= (w_next_state == ST_SEEK) || (w_next_state == ST_DWELL);
      r_done   <= (w_next_state == ST_DONE);
    end
  end

  assign target_value = r_target;
  assign index        = r_index;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_setpoint_sequencer.sv
// tb/tb_setpoint_sequencer.sv - directed bench with a slot/phase model of the sequencer
module tb_setpoint_sequencer;

  localparam int DEPTH = 4;
  localparam logic [7:0] INIT = 8'd0;
  localparam int M_IDLE = 0, M_SEEK = 1, M_DWELL = 2, M_DONE = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        write_enable = 1'b0;
  logic [1:0]  write_address = 2'd0;
  logic [7:0]  write_data = 8'd0;
  logic [15:0] dwell_cycles = 16'd3;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  actual_value = 8'd0;
  logic [7:0]  target_value;
  logic [1:0]  index;
  logic        busy;
  logic        done;

  bit          follow_en = 1'b1;
  logic [7:0]  manual_actual = 8'd0;
  int          total = 0;
  int          bad = 0;

  int m_mode = M_IDLE;
  int m_target = 0;
  int m_index = 0;
  int m_need = 0;
  int m_spent = 0;
  int m_slots [DEPTH];

  int exp_t [4] = '{10, 20, 20, 5};
  int entries [$];
  int cnt [4] = '{0, 0, 0, 0};
  logic       prev_busy;
  logic [1:0] prev_idx;

  setpoint_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .dwell_cycles  (dwell_cycles),
    .start         (start),
    .abort         (abort),
    .actual_value  (actual_value),
    .target_value  (target_value),
    .index         (index),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Follower plant: slews toward the target by at most 6 per cycle.
  always @(posedge clock) begin
    int d;
    #2;
    if (follow_en) begin
      d = int'(target_value) - int'(actual_value);
      if (d > 6)       actual_value = actual_value + 8'd6;
      else if (d < -6) actual_value = actual_value - 8'd6;
      else             actual_value = target_value;
    end else begin
      actual_value = manual_actual;
    end
  end

  // Model: a step holds for dwell_cycles+1 cycles once the follower has arrived.
  always @(posedge clock) begin
    if (reset) begin
      m_mode = M_IDLE; m_target = int'(INIT); m_index = 0; m_need = 0; m_spent = 0;
    end else begin
      if (abort) begin
        m_mode = M_IDLE; m_target = int'(actual_value);
      end else if ((m_mode == M_IDLE || m_mode == M_DONE) && start) begin
        m_mode = M_SEEK; m_index = 0; m_target = m_slots[0];
      end else if (m_mode == M_SEEK && int'(actual_value) == m_target) begin
        m_mode = M_DWELL; m_need = int'(dwell_cycles) + 1; m_spent = 0;
      end else if (m_mode == M_DWELL) begin
        m_spent++;
        if (m_spent == m_need) begin
          if (m_index < DEPTH - 1) begin
            m_index++; m_target = m_slots[m_index]; m_mode = M_SEEK;
          end else begin
`ifdef SETPOINT_SEQUENCER_LOOP_EN
            m_index = 0; m_target = m_slots[0]; m_mode = M_SEEK;
`else
            m_mode = M_DONE;
`endif
          end
        end
      end
      if (write_enable) m_slots[write_address] = int'(write_data);
    end
  end

  always @(negedge clock) begin
    check("cmp_target", int'(target_value), m_target);
    check("cmp_index", int'(index), m_index);
    check("cmp_busy", int'(busy), int'(m_mode == M_SEEK || m_mode == M_DWELL));
    check("cmp_done", int'(done), int'(m_mode == M_DONE));
  end

  function automatic bit cond(input int which, input int arg);
    case (which)
      1:       return busy && (int'(index) == arg) && (actual_value == target_value);
      2:       return busy && (int'(index) == arg);
      default: return done;
    endcase
  endfunction

  task automatic wait_cond(input string name, input int which, input int arg);
    for (int i = 0; i < 400; i++) begin
      if (cond(which, arg)) break;
      @(negedge clock);
    end
    check(name, int'(cond(which, arg)), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clock); start = 1'b0;
  endtask

  task automatic finish_run(input string name);
`ifdef SETPOINT_SEQUENCER_LOOP_EN
    wait_cond({name, "_last"}, 2, 3);
    wait_cond({name, "_wrap"}, 2, 0);
    check({name, "_loop_done"}, int'(done), 0);
    abort = 1'b1; @(negedge clock); abort = 1'b0;
`else
    wait_cond({name, "_done"}, 3, 0);
`endif
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("reset_target", int'(target_value), 0);
    check("reset_index", int'(index), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    reset = 1'b0;

    for (int k = 0; k < 4; k++) begin
      write_enable = 1'b1; write_address = 2'(k); write_data = 8'(exp_t[k]);
      @(negedge clock);
    end
    write_enable = 1'b0;

    // Full profile run with the follower in the loop.
    pulse_start();
    prev_busy = 1'b0; prev_idx = 2'd0;
    for (int i = 0; i < 400; i++) begin
      if (busy && (!prev_busy || index != prev_idx)) entries.push_back(int'(target_value));
      if (busy && actual_value == target_value) cnt[index]++;
      prev_busy = busy; prev_idx = index;
`ifdef SETPOINT_SEQUENCER_LOOP_EN
      if (entries.size() == 5) break;
`else
      if (done) break;
`endif
      @(negedge clock);
    end
`ifdef SETPOINT_SEQUENCER_LOOP_EN
    check("run1_steps", entries.size(), 5);
    if (entries.size() == 5) check("run1_wrap_target", entries[4], 10);
    check("run1_wrap_index", int'(index), 0);
    check("run1_wrap_done", int'(done), 0);
    abort = 1'b1; @(negedge clock); abort = 1'b0;
`else
    check("run1_steps", entries.size(), 4);
    check("run1_done", int'(done), 1);
    check("run1_final_target", int'(target_value), 5);
    check("run1_final_index", int'(index), 3);
`endif
    for (int k = 0; k < 4; k++) begin
      if (k < entries.size()) check($sformatf("run1_step%0d_target", k), entries[k], exp_t[k]);
      check($sformatf("run1_step%0d_arrive_plus_dwell", k), cnt[k], 5);
    end

    // Abort while seeking: target freezes at the follower's position.
    follow_en = 1'b0; manual_actual = 8'd14;
    write_enable = 1'b1; write_address = 2'd0; write_data = 8'd20;
    @(negedge clock);
    write_enable = 1'b0;
    @(negedge clock);
    pulse_start();
    repeat (2) @(negedge clock);
    check("seek_target", int'(target_value), 20);
    check("seek_busy", int'(busy), 1);
    abort = 1'b1; @(negedge clock); abort = 1'b0;
    check("abort_target", int'(target_value), 14);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_index", int'(index), 0);
    abort = 1'b1; start = 1'b1; @(negedge clock); abort = 1'b0; start = 1'b0;
    check("abort_beats_start_busy", int'(busy), 0);

    // Start while busy is ignored.
    follow_en = 1'b1;
    pulse_start();
    wait_cond("reach_slot1", 1, 1);
    pulse_start();
    check("busy_start_index", int'(index), 1);
    check("busy_start_target", int'(target_value), 20);
    check("busy_start_busy", int'(busy), 1);
    abort = 1'b1; @(negedge clock); abort = 1'b0;

    // Write slot 1 on the very edge that loads it.
    dwell_cycles = 16'd0;
    pulse_start();
    wait_cond("reach_slot0", 1, 0);
    @(negedge clock);
    write_enable = 1'b1; write_address = 2'd1; write_data = 8'd99;
    @(negedge clock);
    write_enable = 1'b0;
    check("wr_same_edge_index", int'(index), 1);
    check("wr_same_edge_target", int'(target_value), 20);
    finish_run("run3");
    dwell_cycles = 16'd3;
    pulse_start();
    wait_cond("reach_slot1_new", 2, 1);
    check("new_slot1_target", int'(target_value), 99);

    // Reset in DWELL abandons the run but keeps the slots.
    wait_cond("reach_slot1_dwell", 1, 1);
    @(negedge clock);
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    check("rst_target", int'(target_value), int'(INIT));
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_index", int'(index), 0);
    pulse_start();
    check("kept_slot0", int'(target_value), 20);
    wait_cond("kept_reach1", 2, 1);
    check("kept_slot1", int'(target_value), 99);
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
